// File: rtl/store_loader.sv
// rtl/store_loader.sv - loads a program image into the store, optionally verifies it, then hands the store to the CPU
// Optional read-back verify and ERROR state: define STORE_LOADER_VERIFY_EN.
module store_loader #(
    parameter int WORDS = 32,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    output logic [AW-1:0] prog_addr,
    input  logic [DW-1:0] prog_data,
    output logic [AW-1:0] st_addr,
    output logic [DW-1:0] st_wdata,
    output logic          st_we,
    input  logic [DW-1:0] st_rdata,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    input  logic          cpu_we,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_run,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic [AW-1:0] err_addr
);

    localparam logic [AW-1:0] LAST = AW'(WORDS - 1);

`ifdef STORE_LOADER_VERIFY_EN
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_VERIFY, S_RUN, S_ERROR} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_t;
`endif

    state_t        state;
    state_t        state_nx;
    logic [AW-1:0] cnt;

`ifdef STORE_LOADER_VERIFY_EN
    logic [AW-1:0] cmp_addr;
    logic          cmp_valid;
    logic          tail;
    logic          mismatch;
    logic [AW-1:0] err_addr_q;

    // st_rdata lags st_addr by a cycle, so the comparison uses the address issued last cycle
    assign mismatch = (state == S_VERIFY) && cmp_valid && (st_rdata != prog_data);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cmp_addr   <= '0;
            cmp_valid  <= 1'b0;
            tail       <= 1'b0;
            err_addr_q <= '0;
        end else if (state == S_VERIFY) begin
            if (mismatch) begin
                err_addr_q <= cmp_addr;
            end else if (!tail) begin
                cmp_addr  <= cnt;
                cmp_valid <= 1'b1;
                if (cnt == LAST) begin
                    tail <= 1'b1;
                end
            end
        end else begin
            cmp_valid <= 1'b0;
            tail      <= 1'b0;
        end
    end

    assign err_addr = err_addr_q;
    assign error    = (state == S_ERROR);
`else
    assign err_addr = '0;
    assign error    = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Terminal count is an explicit compare on LAST; the counter is parked at zero outside a pass
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (state == S_LOAD) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
`ifdef STORE_LOADER_VERIFY_EN
        end else if (state == S_VERIFY && !mismatch && !tail) begin
            if (cnt != LAST) begin
                cnt <= cnt + 1'b1;
            end
`endif
        end else begin
            cnt <= '0;
        end
    end

    always_comb begin
        state_nx  = state;
        prog_addr = cnt;
        st_addr   = '0;
        st_wdata  = '0;
        st_we     = 1'b0;
        cpu_run   = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = S_LOAD;
                end
            end
            S_LOAD: begin
                busy     = 1'b1;
                st_addr  = cnt;
                st_wdata = prog_data;
                st_we    = 1'b1;
                if (cnt == LAST) begin
`ifdef STORE_LOADER_VERIFY_EN
                    state_nx = S_VERIFY;
`else
                    state_nx = S_RUN;
`endif
                end
            end
`ifdef STORE_LOADER_VERIFY_EN
            S_VERIFY: begin
                busy      = 1'b1;
                st_addr   = cnt;
                prog_addr = cmp_addr;
                if (mismatch) begin
                    state_nx = S_ERROR;
                end else if (tail) begin
                    state_nx = S_RUN;
                end
            end
            S_ERROR: begin
                if (start) begin
                    state_nx = S_LOAD;
                end
            end
`endif
            S_RUN: begin
                cpu_run  = 1'b1;
                done     = 1'b1;
                st_addr  = cpu_addr;
                st_wdata = cpu_wdata;
                st_we    = cpu_we;
                if (start) begin
                    state_nx = S_LOAD;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    assign cpu_rdata = st_rdata;

endmodule

// File: tb/tb_store_loader.sv
// tb/tb_store_loader.sv - self-checking bench for store_loader against a behavioural store/image model
module tb_store_loader;

    localparam int WORDS = 32;
    localparam int AW    = 5;
    localparam int DW    = 32;
`ifdef STORE_LOADER_VERIFY_EN
    localparam int RUN_CYC = 2 * WORDS + 2;
`else
    localparam int RUN_CYC = WORDS + 1;
`endif

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] prog_addr, st_addr, err_addr;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] prog_data, st_wdata, cpu_rdata;
    logic [DW-1:0] st_rdata;
    logic [DW-1:0] cpu_wdata = '0;
    logic          st_we, cpu_run, busy, done, error;
    logic          cpu_we = 1'b0;

    logic [DW-1:0] image [WORDS];
    logic [DW-1:0] store [WORDS];
    bit            corrupt_en = 1'b0;
    logic [AW-1:0] corrupt_addr = '0;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int   cyc;
        logic start;
        logic busy;
        logic run;
        logic we;
    } vec_t;
    vec_t vt[$];

    always #5 clk = ~clk;

    assign prog_data = image[prog_addr];

    always @(posedge clk) begin
        st_rdata <= (corrupt_en && st_addr == corrupt_addr) ? ~store[st_addr] : store[st_addr];
        if (st_we) store[st_addr] <= st_wdata;
    end

    store_loader #(.WORDS(WORDS), .AW(AW), .DW(DW)) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .prog_addr(prog_addr), .prog_data(prog_data),
        .st_addr(st_addr), .st_wdata(st_wdata), .st_we(st_we), .st_rdata(st_rdata),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we), .cpu_rdata(cpu_rdata),
        .cpu_run(cpu_run), .busy(busy), .done(done), .error(error), .err_addr(err_addr)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic check_reset(input string tag);
        check({tag, " prog_addr"}, prog_addr, 0);
        check({tag, " st_addr"}, st_addr, 0);
        check({tag, " st_wdata"}, st_wdata, 0);
        check({tag, " st_we"}, st_we, 0);
        check({tag, " cpu_run"}, cpu_run, 0);
        check({tag, " busy"}, busy, 0);
        check({tag, " done"}, done, 0);
        check({tag, " error"}, error, 0);
        check({tag, " err_addr"}, err_addr, 0);
    endtask

    // Pulses start and expects exactly WORDS in-order writes of the image, then RUN at RUN_CYC
    task automatic load_and_check(input string tag, input bit noise);
        int nw;
        bit seen;
        nw = 0;
        seen = 0;
        cpu_we = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c < 200 && !seen; c++) begin
            if (noise) begin
                cpu_we = 1'b1;
                cpu_addr = AW'($urandom);
                cpu_wdata = $urandom;
            end
            #1;
            if (c == 1) begin
                check({tag, " entry busy"}, busy, 1);
                check({tag, " entry done"}, done, 0);
                check({tag, " entry error"}, error, 0);
                check({tag, " entry cpu_run"}, cpu_run, 0);
            end
            if (cpu_run) begin
                seen = 1;
                cpu_we = 1'b0;
                check({tag, " run_cycle"}, c, RUN_CYC);
                check({tag, " done"}, done, 1);
                check({tag, " busy_in_run"}, busy, 0);
            end else begin
                if (st_we) begin
                    if (nw < WORDS) begin
                        check({tag, " wr_addr"}, st_addr, nw);
                        check({tag, " wr_data"}, st_wdata, image[nw]);
                    end
                    nw++;
                end
                step();
            end
        end
        cpu_we = 1'b0;
        check({tag, " reached_run"}, seen, 1);
        check({tag, " write_count"}, nw, WORDS);
        for (int i = 0; i < WORDS; i++) begin
            check({tag, " store_content"}, store[i], image[i]);
        end
    endtask

    // Random CPU traffic in RUN against a plain array model of the store
    task automatic cpu_ops(input string tag, input int n);
        logic [DW-1:0] refm [WORDS];
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          w;
        for (int i = 0; i < WORDS; i++) refm[i] = image[i];
        for (int k = 0; k < n; k++) begin
            a = AW'($urandom);
            d = $urandom;
            w = 1'($urandom_range(0, 1));
            if (k == 0) begin a = 5; d = 32'hDEADBEEF; w = 1'b1; end
            if (k == 1) begin a = 5; w = 1'b0; end
            cpu_addr = a;
            cpu_wdata = d;
            cpu_we = w;
            #1;
            check({tag, " cpu_run"}, cpu_run, 1);
            check({tag, " st_addr"}, st_addr, a);
            check({tag, " st_wdata"}, st_wdata, d);
            check({tag, " st_we"}, st_we, w);
            step();
            check({tag, " cpu_rdata"}, cpu_rdata, refm[a]);
            if (w) refm[a] = d;
        end
        cpu_we = 1'b0;
    endtask

    initial begin
        int idx;
        int nw;
        int last;
        bit seen;

        for (int i = 0; i < WORDS; i++) image[i] = 32'h01010101 * i;

        #1 reset_n = 1'b0;
        #1 check_reset("reset");
        step();
        step();
        reset_n = 1'b1;
        step();
        step();
        step();
        #1;
        check("no_self_start busy", busy, 0);
        check("no_self_start st_we", st_we, 0);
        check("no_self_start cpu_run", cpu_run, 0);

`ifdef STORE_LOADER_VERIFY_EN
        vt.push_back('{0, 1'b1, 1'b0, 1'b0, 1'b0});
        vt.push_back('{1, 1'b0, 1'b1, 1'b0, 1'b1});
        vt.push_back('{10, 1'b1, 1'b1, 1'b0, 1'b1});
        vt.push_back('{32, 1'b0, 1'b1, 1'b0, 1'b1});
        vt.push_back('{33, 1'b0, 1'b1, 1'b0, 1'b0});
        vt.push_back('{40, 1'b1, 1'b1, 1'b0, 1'b0});
        vt.push_back('{65, 1'b0, 1'b1, 1'b0, 1'b0});
        vt.push_back('{66, 1'b0, 1'b0, 1'b1, 1'b0});
        vt.push_back('{70, 1'b0, 1'b0, 1'b1, 1'b0});
`else
        vt.push_back('{0, 1'b1, 1'b0, 1'b0, 1'b0});
        vt.push_back('{1, 1'b0, 1'b1, 1'b0, 1'b1});
        vt.push_back('{10, 1'b1, 1'b1, 1'b0, 1'b1});
        vt.push_back('{32, 1'b0, 1'b1, 1'b0, 1'b1});
        vt.push_back('{33, 1'b0, 1'b0, 1'b1, 1'b0});
        vt.push_back('{40, 1'b0, 1'b0, 1'b1, 1'b0});
`endif
        idx = 0;
        nw = 0;
        last = vt[vt.size() - 1].cyc;
        for (int c = 0; c <= last; c++) begin
            start = (idx < vt.size() && vt[idx].cyc == c) ? vt[idx].start : 1'b0;
            #1;
            if (st_we && !cpu_run) begin
                if (nw < WORDS) check("tbl wr_addr", st_addr, nw);
                nw++;
            end
            if (idx < vt.size() && vt[idx].cyc == c) begin
                check($sformatf("tbl c%0d busy", c), busy, vt[idx].busy);
                check($sformatf("tbl c%0d cpu_run", c), cpu_run, vt[idx].run);
                check($sformatf("tbl c%0d done", c), done, vt[idx].run);
                check($sformatf("tbl c%0d st_we", c), st_we, vt[idx].we);
                idx++;
            end
            step();
        end
        start = 1'b0;
        check("tbl write_count", nw, WORDS);
        for (int i = 0; i < WORDS; i++) check("tbl store_content", store[i], image[i]);

        cpu_ops("run0", 12);

        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < WORDS; i++) image[i] = $urandom;
            load_and_check($sformatf("rand%0d", p), 1'b1);
            cpu_ops($sformatf("rand%0d_cpu", p), 16);
        end

`ifdef STORE_LOADER_VERIFY_EN
        for (int i = 0; i < WORDS; i++) image[i] = 32'h01010101 * i;
        corrupt_addr = 17;
        corrupt_en = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        seen = 0;
        for (int c = 1; c < 200 && !seen; c++) begin
            #1;
            if (error) begin
                seen = 1;
                check("fault cycle", c, 52);
            end else begin
                step();
            end
        end
        check("fault seen", seen, 1);
        check("fault err_addr", err_addr, 17);
        check("fault cpu_run", cpu_run, 0);
        check("fault busy", busy, 0);
        for (int k = 0; k < 5; k++) begin
            cpu_we = 1'b1;
            cpu_addr = 3;
            cpu_wdata = $urandom;
            step();
            #1;
            check("err hold error", error, 1);
            check("err hold err_addr", err_addr, 17);
            check("err hold st_we", st_we, 0);
        end
        cpu_we = 1'b0;
        corrupt_en = 1'b0;
        load_and_check("restart_err", 1'b0);
`endif

        start = 1'b1;
        step();
        start = 1'b0;
`ifdef STORE_LOADER_VERIFY_EN
        for (int c = 1; c < 37; c++) step();
`else
        for (int c = 1; c < 20; c++) step();
`endif
        cpu_we = 1'b1;
        cpu_addr = 7;
        cpu_wdata = 32'h12345678;
        #1;
        check("pre_reset busy", busy, 1);
        reset_n = 1'b0;
        #1 check_reset("mid_reset");
        step();
        step();
        reset_n = 1'b1;
        for (int k = 0; k < 4; k++) step();
        #1;
        check("post_reset busy", busy, 0);
        check("post_reset st_we", st_we, 0);
        check("post_reset cpu_run", cpu_run, 0);
        cpu_we = 1'b0;
        load_and_check("after_reset", 1'b0);
        for (int i = 0; i < WORDS; i++) image[i] = $urandom;
        load_and_check("restart_run", 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/store_loader.md
STORE_LOADER -- requirements
Module: store_loader

Interface
REQ-001 Parameter WORDS, default 32, number of store words loaded from the program image.
REQ-002 Parameter AW, default 5, store address width; WORDS SHALL equal 2**AW.
REQ-003 Parameter DW, default 32, store word width.
REQ-004 clk  input  1  Single system clock; all state SHALL update on its rising edge.
REQ-005 reset_n  input  1  Asynchronous, active-low reset.
REQ-006 start  input  1  Single-cycle pulse; requests a program-image load into the store.
REQ-007 prog_addr  output  AW  Address into the program image.
REQ-008 prog_data  input  DW  Program-image word for prog_addr; combinational, valid in the same cycle.
REQ-009 st_addr / st_wdata / st_we  output  AW / DW / 1  Store port: address, write data, write enable.
REQ-010 st_rdata  input  DW  Store read data; valid one cycle after st_addr is presented.
REQ-011 cpu_addr / cpu_wdata / cpu_we  input  AW / DW / 1  CPU store request.
REQ-012 cpu_rdata  output  DW  st_rdata forwarded to the CPU.
REQ-013 cpu_run  output  1  Asserted only in RUN; the CPU SHALL hold while it is low.
REQ-014 busy / done / error  output  1 each  Status flags: load in progress / load completed / verify failure.
REQ-015 err_addr  output  AW  First mismatching address.

Function
REQ-016 States SHALL be IDLE, LOAD, VERIFY, RUN and ERROR.
REQ-017 IDLE: on start, go to LOAD with word counter cnt=0; otherwise remain in IDLE.
REQ-018 LOAD:
- prog_addr=cnt, st_addr=cnt, st_wdata=prog_data, st_we=1.
- cnt increments every cycle.
- Exactly WORDS cycles, writing addresses 0..WORDS-1 in order.
REQ-019 LOAD exit at cnt=WORDS-1: go to VERIFY if verify is compiled in, else to RUN.
REQ-020 VERIFY:
- st_we=0; st_addr=cnt for cnt 0..WORDS-1.
- The word returned in the following cycle SHALL be compared with prog_data for the delayed address; VERIFY lasts WORDS+1 cycles.
REQ-021 First mismatch: capture err_addr, go to ERROR, stop comparing.
REQ-022 No mismatch after the final compare: go to RUN.
REQ-023 RUN: store port SHALL be driven only by the CPU (st_addr=cpu_addr, st_wdata=cpu_wdata, st_we=cpu_we); cpu_run=1; done=1.
REQ-024 Outside RUN: CPU requests SHALL be ignored and cpu_we SHALL never reach st_we.
REQ-025 busy=1 exactly in LOAD and VERIFY.
REQ-026 start in LOAD or VERIFY SHALL be ignored.
REQ-027 start in RUN or ERROR SHALL restart LOAD at cnt=0 on the next cycle; done, error and cpu_run SHALL clear on entry to LOAD.
REQ-028 ERROR: error=1; err_addr held; cpu_run=0; store port idle (st_we=0).
REQ-029 cnt SHALL not wrap within a pass; the terminal count SHALL be detected on cnt=WORDS-1, not by overflow.
REQ-030 cpu_rdata SHALL equal st_rdata in every state; it is meaningful only in RUN.

Reset
REQ-031 reset_n low SHALL force IDLE immediately, independent of clk.
REQ-032 Reset values: cnt=0, prog_addr=0, st_addr=0, st_wdata=0, st_we=0, cpu_run=0, busy=0, done=0, error=0, err_addr=0.
REQ-033 Reset asserted mid-LOAD or mid-VERIFY SHALL abandon the pass; the store contents are then undefined and a new start is required.
REQ-034 Reset release SHALL NOT start a load by itself.

Configuration
REQ-035 Macro STORE_LOADER_VERIFY_EN enables VERIFY (REQ-020..022), the comparator, err_addr capture and the ERROR state.
REQ-036 When STORE_LOADER_VERIFY_EN is undefined:
- LOAD SHALL go directly to RUN.
- error and err_addr SHALL be tied to 0.
- The ERROR state SHALL not exist.

Verification
REQ-037 Load: image word n = n*0x01010101; pulse start -> st_we high for 32 consecutive cycles, addresses 0..31 with matching data; then RUN; cpu_run=1 and done=1.
REQ-038 Latency (verify enabled): start at cycle 0 -> busy=1 for cycles 1..65, cpu_run=1 at cycle 66; verify disabled -> cpu_run=1 at cycle 33.
REQ-039 Verify fault: store model corrupts address 17 -> error=1, err_addr=17, cpu_run=0, no further comparisons.
REQ-040 Isolation: cpu_we=1 held throughout LOAD -> st_wdata always equals prog_data; in RUN, a CPU write of 0xDEADBEEF to address 5 reaches the store unchanged.
REQ-041 Restart and reset: start pulsed at LOAD cycle 10 -> ignored, 32 writes total; reset_n low at VERIFY cycle 4 -> all outputs at reset values immediately; a later start in RUN triggers a full reload.
